// File: rtl/mod_divrem_if.sv
// Operand/result bundle between a requester and the mod_divrem reducer.
//
// Handshake: the requester raises ready_in with value_in/modulus_in stable;
// the reducer accepts on any rising clock edge where it is idle (busy_out=0),
// and ignores ready_in while busy_out=1. Operands are captured at the accept
// edge and may change freely afterwards. Completion is a one-cycle valid_out
// pulse; remainder_out, quotient_out and error_out are meaningful while
// valid_out=1 and hold until the next completion.
interface mod_divrem_if #(
  parameter int WIDTH = 16
);
  logic                 ready_in;
  logic [2*WIDTH-1:0]   value_in;
  logic [WIDTH-1:0]     modulus_in;
  logic [WIDTH-1:0]     remainder_out;
  logic [2*WIDTH-1:0]   quotient_out;
  logic                 busy_out;
  logic                 valid_out;
  logic                 error_out;

  modport master (
    output ready_in, value_in, modulus_in,
    input  remainder_out, quotient_out, busy_out, valid_out, error_out
  );

  modport slave (
    input  ready_in, value_in, modulus_in,
    output remainder_out, quotient_out, busy_out, valid_out, error_out
  );
endinterface

// File: rtl/mod_divrem.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit modulus,
// BITS_PER_CYCLE quotient bits per clock, divide-by-zero flagged in one cycle.
module mod_divrem #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  mod_divrem_if.slave bus,
  output logic [1:0] state_dbg
);

  localparam int DW     = 2 * WIDTH;
  localparam int STEPS  = DW / BITS_PER_CYCLE;
  localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Reject unsupported parameter combinations at elaboration.
  generate
    if ((WIDTH < 2) ||
        !((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) ||
          (BITS_PER_CYCLE == 4) || (BITS_PER_CYCLE == 8)) ||
        ((DW % BITS_PER_CYCLE) != 0)) begin : g_bad_params
      $error("mod_divrem: illegal WIDTH/BITS_PER_CYCLE combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      dvd_q;      // dividend, consumed MSB first
  logic [WIDTH-1:0]   mod_q;
  logic [WIDTH-1:0]   part_q;     // partial remainder; always < mod_q between steps
  logic [DW-1:0]      quo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_out_q;
  logic [DW-1:0]      quo_out_q;
  logic               busy_q, valid_q, error_q;

  logic [WIDTH-1:0]   part_nxt;
  logic [DW-1:0]      dvd_nxt;
  logic [DW-1:0]      quo_nxt;
  logic [WIDTH:0]     trial;      // shifted remainder needs one extra bit
  logic               last_step;

  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  // Chain BITS_PER_CYCLE restoring-division iterations combinationally.
  always_comb begin
    part_nxt = part_q;
    dvd_nxt  = dvd_q;
    quo_nxt  = quo_q;
    trial    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial   = {part_nxt, dvd_nxt[DW-1]};
      dvd_nxt = {dvd_nxt[DW-2:0], 1'b0};
      if (trial >= {1'b0, mod_q}) begin
        trial   = trial - {1'b0, mod_q};
        quo_nxt = {quo_nxt[DW-2:0], 1'b1};
      end else begin
        quo_nxt = {quo_nxt[DW-2:0], 1'b0};
      end
      part_nxt = trial[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.ready_in) state_d = (bus.modulus_in == '0) ? S_ZERO : S_CALC;
      S_CALC: if (last_step)    state_d = S_IDLE;
      S_ZERO:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, advanced according to the current state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dvd_q     <= '0;
      mod_q     <= '0;
      part_q    <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      rem_out_q <= '0;
      quo_out_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.ready_in) begin
            dvd_q  <= bus.value_in;
            mod_q  <= bus.modulus_in;
            part_q <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
          end
        end
        S_CALC: begin
          part_q <= part_nxt;
          dvd_q  <= dvd_nxt;
          quo_q  <= quo_nxt;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step) begin
            rem_out_q <= part_nxt;
            quo_out_q <= quo_nxt;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            error_q   <= 1'b0;
          end
        end
        S_ZERO: begin
          rem_out_q <= '0;
          quo_out_q <= '1;
          busy_q    <= 1'b0;
          valid_q   <= 1'b1;
          error_q   <= 1'b1;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping; everything visible is a register.
  always_comb begin
    state_dbg         = state_q;
    bus.remainder_out = rem_out_q;
    bus.quotient_out  = quo_out_q;
    bus.busy_out      = busy_q;
    bus.valid_out     = valid_q;
    bus.error_out     = error_q;
  end

endmodule

// File: tb/tb_mod_divrem.sv
// Bench for mod_divrem: two WIDTH=16 instances (1 and 4 bits per cycle)
// driven side by side with directed vectors, handshake and reset sequences.
module tb_mod_divrem;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  // ---------------- DUTs ----------------
  logic [1:0]     rdy;
  logic [2*W-1:0] val;
  logic [W-1:0]   mdl;

  mod_divrem_if #(.WIDTH(W)) bus1 ();
  mod_divrem_if #(.WIDTH(W)) bus4 ();

  assign bus1.ready_in   = rdy[0];
  assign bus4.ready_in   = rdy[1];
  assign bus1.value_in   = val;
  assign bus4.value_in   = val;
  assign bus1.modulus_in = mdl;
  assign bus4.modulus_in = mdl;

  logic [1:0] st1, st4;

  mod_divrem #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus1), .state_dbg(st1));
  mod_divrem #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus4), .state_dbg(st4));

  logic [1:0]     vld, bsy, er;
  logic [W-1:0]   rm [2];
  logic [2*W-1:0] qu [2];
  assign vld   = {bus4.valid_out, bus1.valid_out};
  assign bsy   = {bus4.busy_out,  bus1.busy_out};
  assign er    = {bus4.error_out, bus1.error_out};
  assign rm[0] = bus1.remainder_out;
  assign rm[1] = bus4.remainder_out;
  assign qu[0] = bus1.quotient_out;
  assign qu[1] = bus4.quotient_out;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issue one operation to both DUTs, then follow each to its valid pulse.
  // pXa/pXb: negedge indices after accept at which a stray ready_in with
  // different operands is raised for that DUT (0 = none).
  task automatic run_op(input logic [2*W-1:0] v, input logic [W-1:0] m,
                        input logic [W-1:0] er_exp, input logic [2*W-1:0] q_exp,
                        input logic e_exp, input string nm,
                        input int p1a = 0, input int p1b = 0,
                        input int p4a = 0, input int p4b = 0);
    int  lat [2];
    int  bcnt [2];
    bit  done [2];
    string dn;
    lat[0] = e_exp ? 1 : 32;
    lat[1] = e_exp ? 1 : 8;
    bcnt[0] = 0; bcnt[1] = 0;
    done[0] = 1'b0; done[1] = 1'b0;
    @(negedge clk_in);
    rdy = 2'b11; val = v; mdl = m;
    @(posedge clk_in);
    #1;
    rdy = 2'b00; val = ~v; mdl = m ^ 16'h5A5A;
    for (int k = 1; k <= 80 && !(done[0] && done[1]); k++) begin
      @(negedge clk_in);
      for (int d = 0; d < 2; d++) begin
        dn = $sformatf("%s/b%0d", nm, (d == 0) ? 1 : 4);
        if (!done[d]) begin
          if (vld[d]) begin
            done[d] = 1'b1;
            chk({dn, "/rem"},     64'(rm[d]), 64'(er_exp));
            chk({dn, "/quo"},     64'(qu[d]), 64'(q_exp));
            chk({dn, "/err"},     64'(er[d]), 64'(e_exp));
            chk({dn, "/latency"}, 64'(k - 1), 64'(lat[d]));
            chk({dn, "/busycyc"}, 64'(bcnt[d]), 64'(lat[d]));
          end else if (bsy[d]) begin
            bcnt[d]++;
          end
        end
      end
      rdy[0] = (k == p1a) || (k == p1b);
      rdy[1] = (k == p4a) || (k == p4b);
    end
    rdy = 2'b00;
    for (int d = 0; d < 2; d++)
      if (!done[d]) chk({nm, "/timeout"}, 64'd1, 64'd0);
    @(negedge clk_in);
    chk({nm, "/valid_pulse"}, 64'(vld), 64'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2*W-1:0] v;
    logic [W-1:0]   m;
    logic [W-1:0]   r;
    logic [2*W-1:0] q;
    logic           e;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [2*W-1:0] rv;
    logic [W-1:0]   rmod;
    int             phase [2];
    int             seen;

    vecs[0]  = '{32'h0001_2345, 16'h00FF, 16'h0069, 32'h0000_0124, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 16'hFFFF, 16'h0000, 32'h0001_0001, 1'b0};
    vecs[2]  = '{32'hDEAD_BEEF, 16'h0001, 16'h0000, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{32'h0000_1234, 16'h8000, 16'h1234, 32'h0000_0000, 1'b0};
    vecs[4]  = '{32'h0000_1234, 16'h0000, 16'h0000, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{32'h8000_0000, 16'h8000, 16'h0000, 32'h0001_0000, 1'b0};
    vecs[6]  = '{32'h0000_0000, 16'h1234, 16'h0000, 32'h0000_0000, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 16'h0002, 16'h0001, 32'h7FFF_FFFF, 1'b0};
    vecs[8]  = '{32'h0000_0064, 16'h0007, 16'h0002, 32'h0000_000E, 1'b0};
    vecs[9]  = '{32'h1234_5678, 16'h0100, 16'h0078, 32'h0012_3456, 1'b0};
    vecs[10] = '{32'h0001_0000, 16'h0003, 16'h0001, 32'h0000_5555, 1'b0};
    vecs[11] = '{32'hFFFE_0001, 16'hFFFF, 16'h0000, 32'h0000_FFFF, 1'b0};

    rst_n_in = 1'b0;
    rdy = 2'b00; val = '0; mdl = '0;
    #1;
    chk("reset/rem",   64'({rm[1], rm[0]}), 64'd0);
    chk("reset/quo",   64'({qu[1], qu[0]}), 64'd0);
    chk("reset/flags", 64'({bsy, vld, er}), 64'd0);
    chk("reset/state", 64'({st4, st1}), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].v, vecs[i].m, vecs[i].r, vecs[i].q, vecs[i].e,
             $sformatf("vec%0d", i));

    // Stray ready_in pulses while busy must be ignored.
    run_op(32'h0001_2345, 16'h00FF, 16'h0069, 32'h0000_0124, 1'b0,
           "ignore_ready", 3, 10, 3, 7);

    // Back-to-back: ready_in held through the valid cycle.
    @(negedge clk_in);
    rdy = 2'b11; val = 32'hFFFF_FFFF; mdl = 16'hFFFF;
    @(posedge clk_in);
    #1;
    val = 32'h1234_5678; mdl = 16'h0100;
    phase[0] = 0; phase[1] = 0;
    for (int k = 1; k <= 120 && !(phase[0] == 3 && phase[1] == 3); k++) begin
      @(negedge clk_in);
      for (int d = 0; d < 2; d++) begin
        case (phase[d])
          0: if (vld[d]) begin
               chk("b2b/first_rem", 64'(rm[d]), 64'h0);
               chk("b2b/first_quo", 64'(qu[d]), 64'h0001_0001);
               phase[d] = 1;
             end
          1: begin
               chk("b2b/no_gap", 64'({bsy[d], vld[d]}), 64'b10);
               rdy[d] = 1'b0;
               phase[d] = 2;
             end
          2: if (vld[d]) begin
               chk("b2b/second_rem", 64'(rm[d]), 64'h78);
               chk("b2b/second_quo", 64'(qu[d]), 64'h0012_3456);
               phase[d] = 3;
             end
          default: ;
        endcase
      end
    end
    rdy = 2'b00;
    chk("b2b/complete", 64'((phase[0] == 3) && (phase[1] == 3)), 64'd1);

    // Asynchronous reset mid-operation, between clock edges.
    @(negedge clk_in);
    rdy = 2'b11; val = 32'h0001_2345; mdl = 16'h00FF;
    @(posedge clk_in);
    #1;
    rdy = 2'b00;
    repeat (4) @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("abort/rem",   64'({rm[1], rm[0]}), 64'd0);
    chk("abort/quo",   64'({qu[1], qu[0]}), 64'd0);
    chk("abort/flags", 64'({bsy, vld, er}), 64'd0);
    chk("abort/state", 64'({st4, st1}), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (vld != 2'b00) seen++;
    end
    chk("abort/no_valid", 64'(seen), 64'd0);
    run_op(32'h0000_0064, 16'h0007, 16'h0002, 32'h0000_000E, 1'b0, "after_abort");

    // Random operands against the language's own / and %.
    for (int i = 0; i < 40; i++) begin
      rv   = $urandom;
      rmod = 16'($urandom_range(1, 16'hFFFF));
      if (i % 8 == 0) rmod = 16'($urandom_range(1, 15));
      run_op(rv, rmod, 16'(rv % 32'(rmod)), rv / 32'(rmod), 1'b0,
             $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_divrem.md
Name: mod_divrem

Overview:
- Parametrised sequential modular reducer for the keychain arithmetic datapath; next generation of the single-modulus reduction block.
- Computes remainder and full quotient of a 2*WIDTH-bit value by a WIDTH-bit modulus using restoring long division, retiring BITS_PER_CYCLE dividend bits per clock.
- Flags divide-by-zero.
- Feeds the modular exponentiation and key-generation blocks through a start/busy/valid handshake.

Parameters:
- WIDTH, 16, modulus and remainder width; legal range 2 or more.
- BITS_PER_CYCLE, 1, dividend bits retired per compute cycle; legal values 1, 2, 4 or 8, and it must divide 2*WIDTH. Any illegal value is an elaboration error.

Ports:
- clk_in  input  1  sole clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- ready_in  input  1  start request; sampled only when idle.
- value_in  input  2*WIDTH  dividend; captured on accept.
- modulus_in  input  WIDTH  divisor; captured on accept.
- remainder_out  output  WIDTH  value_in mod modulus_in.
- quotient_out  output  2*WIDTH  value_in div modulus_in.
- busy_out  output  1  operation in progress.
- valid_out  output  1  one-cycle result strobe.
- error_out  output  1  divide-by-zero; qualified by valid_out.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset: rst_n_in low immediately clears all state and outputs, whether idle or mid-operation. remainder_out=0, quotient_out=0, busy_out=0, valid_out=0, error_out=0, FSM=IDLE, step counter=0. No result is emitted for an aborted operation.
- FSM states: IDLE, CALC, ZERO. All outputs are registered.
- Accept: ready_in=1 while FSM=IDLE, at edge E0.
  - Capture value_in and modulus_in; set busy_out=1; clear the partial remainder (WIDTH+1 bits internal) and the quotient.
  - Next state is CALC, or ZERO if modulus_in==0.
- ready_in while busy is ignored; there is no queuing and captured operands are unaffected.
- Operand changes after E0 have no effect.
- CALC, per cycle, BITS_PER_CYCLE iterations chained combinationally, MSB of dividend first:
  - r = {r, next dividend bit}.
  - If r >= m then r = r - m and the quotient bit is 1; else the quotient bit is 0.
- Step counter runs 0..C-1, with C = 2*WIDTH/BITS_PER_CYCLE.
- At the edge completing step C-1:
  - Load remainder_out and quotient_out.
  - busy_out<=0, valid_out<=1, error_out<=0; FSM<=IDLE.
- Latency: valid_out is high in the cycle following edge E0+C. busy_out is high for exactly C cycles.
- ZERO: at edge E0+1, remainder_out<=0, quotient_out<=all ones, error_out<=1, valid_out<=1, busy_out<=0, FSM<=IDLE. busy_out is high for exactly 1 cycle.
- valid_out is a single-cycle pulse, cleared at the next edge unless a new completion occurs.
- Result outputs and error_out hold until the next completion.
- Back-to-back: ready_in high in the valid_out cycle is accepted, since the FSM is IDLE. busy_out rises at that edge while valid_out falls.
- Arithmetic invariants:
  - remainder < modulus, always.
  - quotient*modulus + remainder == value_in exactly.
  - The quotient never overflows because it is 2*WIDTH bits.
- Modulus 1 gives remainder 0 and quotient = value_in.
- value_in < modulus gives quotient 0 and remainder = value_in.

Test Plan:
- WIDTH=16, B=1: value 0x0001_2345, modulus 0x00FF -> remainder 0x0069, quotient 0x0000_0124. valid_out exactly 32 cycles after accept; busy_out high 32 cycles.
- WIDTH=16, B=4: value 0xFFFF_FFFF, modulus 0xFFFF -> remainder 0x0000, quotient 0x0001_0001, latency 8. Then value 0xDEAD_BEEF, modulus 0x0001 -> remainder 0, quotient 0xDEAD_BEEF.
- Value 0x0000_1234, modulus 0x8000 -> remainder 0x1234, quotient 0, error_out=0. Next, modulus 0 -> after 1 busy cycle, valid_out=1, error_out=1, remainder 0, quotient 0xFFFF_FFFF.
- Handshake: pulse ready_in on cycles 3 and 10 of a busy operation with different operands -> both ignored, original result returned. ready_in held through the valid_out cycle -> second operation accepted back-to-back with no idle gap.
- Reset: assert rst_n_in low asynchronously mid-CALC, between clock edges -> all outputs 0 immediately. After release, no valid_out for the aborted operation; a fresh operation completes correctly.
- Random regression, 10k operands per B in {1,2,4,8}, WIDTH in {8,16,32} -> matches reference % and /. Latency always 2*WIDTH/B.
